// File: rtl/scc_run_ctrl_pkg.sv
// Shared types and constants for the SCC run controller.
package scc_run_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_STEP_WAIT,
    S_STEP,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_BUDGET = 2'b00;
  localparam logic [1:0] MODE_HALT   = 2'b01;
  localparam logic [1:0] MODE_STEP   = 2'b10;

  localparam logic [1:0] ST_ABORT  = 2'b00;
  localparam logic [1:0] ST_HALT   = 2'b01;
  localparam logic [1:0] ST_BUDGET = 2'b10;
  localparam logic [1:0] ST_ERR    = 2'b11;

endpackage

// File: rtl/scc_run_ctrl_if.sv
// Core-side link between the run controller and scc_f25_top.
interface scc_run_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic              core_rst;
  logic              core_clk_en;
  logic              halt_f;
  logic [1:0]        err_bits;
  logic [DATA_W-1:0] instr_v;

  modport master (
    output core_rst, core_clk_en,
    input  halt_f, err_bits, instr_v
  );

  modport slave (
    input  core_rst, core_clk_en,
    output halt_f, err_bits, instr_v
  );
endinterface

// File: rtl/scc_run_ctrl_trace_ring.sv
// Circular trace of the most recent instruction words; reads are oldest-relative.
module scc_trace_ring #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     we,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_addr;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (we) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (count != (PTR_W+1)'(DEPTH))
        count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we)
      mem[wr_ptr] <= wdata;
  end

  // Oldest entry sits count slots behind the write pointer; wrap is implicit in PTR_W.
  always_comb begin
    rd_addr = wr_ptr - count[PTR_W-1:0] + rd_idx;
    rd_data = ({1'b0, rd_idx} < count) ? mem[rd_addr] : '0;
  end

endmodule

// File: rtl/scc_run_ctrl.sv
// Run controller for the SCC core: reset sequencing, budget/halt/single-step runs,
// termination status and an instruction trace.
module scc_run_ctrl
  import scc_run_pkg::*;
#(
  parameter int unsigned RST_CYCLES  = 3,
  parameter int unsigned MAX_CYCLES  = 750,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TRACE_DEPTH = 8,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [1:0]                     mode,
  input  logic                           step,
  input  logic                           abort,
  scc_run_ctrl_if.master                 core,
  output logic                           busy,
  output logic                           done,
  output logic [1:0]                     status,
  output logic [1:0]                     err_latched,
  output logic [CNT_W-1:0]               cycle_count,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
  output logic [DATA_W-1:0]              trace_rd_data,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count
);
  localparam int unsigned RC_W = $clog2(RST_CYCLES + 1);

  state_t          state, state_n;
  logic [1:0]      mode_q;
  logic [RC_W-1:0] rcnt;
  logic            take_start;
  logic            adv;
  logic            term;
  logic [1:0]      term_st;
  logic            ev;
  logic [1:0]      ev_st;

  // Core-event termination shared by RUN, STEP and STEP_WAIT.
  always_comb begin
    ev    = 1'b1;
    ev_st = ST_ABORT;
    if (core.err_bits != '0)  ev_st = ST_ERR;
    else if (core.halt_f)     ev_st = ST_HALT;
    else if (abort)           ev_st = ST_ABORT;
    else                      ev    = 1'b0;
  end

  always_comb begin
    state_n    = state;
    take_start = 1'b0;
    adv        = 1'b0;
    term       = 1'b0;
    term_st    = ST_ABORT;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n    = S_RESET;
          take_start = 1'b1;
        end
      end
      S_RESET: begin
        if (abort)
          term = 1'b1;
        else if (rcnt == RC_W'(RST_CYCLES - 1))
          state_n = (mode_q == MODE_STEP) ? S_STEP_WAIT : S_RUN;
      end
      S_RUN, S_STEP: begin
        adv = 1'b1;
        if (ev) begin
          term    = 1'b1;
          term_st = ev_st;
        end else if (cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
          term    = 1'b1;
          term_st = ST_BUDGET;
        end else if (state == S_STEP) begin
          state_n = S_STEP_WAIT;
        end
      end
      S_STEP_WAIT: begin
        if (ev) begin
          term    = 1'b1;
          term_st = ev_st;
        end else if (step) begin
          state_n = S_STEP;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (term)
      state_n = S_DONE;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      mode_q           <= MODE_BUDGET;
      rcnt             <= '0;
      cycle_count      <= '0;
      status           <= ST_ABORT;
      err_latched      <= '0;
      done             <= 1'b0;
      busy             <= 1'b0;
      core.core_rst    <= 1'b1;
      core.core_clk_en <= 1'b0;
    end else begin
      state            <= state_n;
      done             <= (state_n == S_DONE) && (state != S_DONE);
      busy             <= state_n inside {S_RESET, S_RUN, S_STEP_WAIT, S_STEP};
      core.core_rst    <= state_n inside {S_IDLE, S_RESET};
      core.core_clk_en <= state_n inside {S_RESET, S_RUN, S_STEP};

      if (state == S_RESET) rcnt <= rcnt + 1'b1;
      else                  rcnt <= '0;

      if (take_start) begin
        mode_q      <= (mode == MODE_STEP) ? MODE_STEP :
                       (mode == MODE_HALT) ? MODE_HALT : MODE_BUDGET;
        cycle_count <= '0;
        status      <= ST_ABORT;
        err_latched <= '0;
      end else if (adv) begin
        cycle_count <= cycle_count + 1'b1;
      end

      if (term) begin
        status      <= term_st;
        err_latched <= (term_st == ST_ERR) ? core.err_bits : 2'b00;
      end
    end
  end

  scc_trace_ring #(
    .DEPTH  (TRACE_DEPTH),
    .DATA_W (DATA_W)
  ) u_trace (
    .clk     (clk),
    .rst     (rst),
    .clr     (take_start),
    .we      (adv),
    .wdata   (core.instr_v),
    .rd_idx  (trace_rd_idx),
    .rd_data (trace_rd_data),
    .count   (trace_count)
  );

endmodule

// File: tb/tb_scc_run_ctrl.sv
// Scoreboard bench for scc_run_ctrl with a simple core model that advances when enabled.
module tb_scc_run_ctrl;
  import scc_run_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam logic [31:0] BASE   = 32'hC0DE_0000;

  logic              clk = 1'b0;
  logic              rst, start, step, abort;
  logic [1:0]        mode;
  logic [2:0]        trace_rd_idx;
  logic              busy, done;
  logic [1:0]        status, err_latched;
  logic [CNT_W-1:0]  cycle_count;
  logic [DATA_W-1:0] trace_rd_data;
  logic [3:0]        trace_count;

  scc_run_ctrl_if #(.DATA_W(DATA_W)) cif ();

  scc_run_ctrl #(
    .RST_CYCLES  (3),
    .MAX_CYCLES  (750),
    .CNT_W       (CNT_W),
    .TRACE_DEPTH (8),
    .DATA_W      (DATA_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mode          (mode),
    .step          (step),
    .abort         (abort),
    .core          (cif),
    .busy          (busy),
    .done          (done),
    .status        (status),
    .err_latched   (err_latched),
    .cycle_count   (cycle_count),
    .trace_rd_idx  (trace_rd_idx),
    .trace_rd_data (trace_rd_data),
    .trace_count   (trace_count)
  );

  always #5 clk = ~clk;

  // Core model: program counter advances on every enabled, non-reset cycle.
  logic [CNT_W-1:0] core_pc;
  int unsigned      halt_at = 0;
  int unsigned      err_at  = 0;
  logic [1:0]       err_val = 2'b00;

  always @(posedge clk) begin
    if (cif.core_rst)         core_pc <= '0;
    else if (cif.core_clk_en) core_pc <= core_pc + 1'b1;
  end

  assign cif.instr_v  = BASE + 32'(core_pc);
  assign cif.halt_f   = (halt_at != 0) && !cif.core_rst && (32'(core_pc) == halt_at - 1);
  assign cif.err_bits = ((err_at != 0) && !cif.core_rst && (32'(core_pc) == err_at - 1)) ? err_val : 2'b00;

  typedef struct {
    logic [1:0]  st;
    logic [1:0]  el;
    int unsigned cc;
    int unsigned tc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_run, n_rph;
  logic seen_done;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_unexpected: got done pulse, expected none");
      end else begin
        e = exp_q.pop_front();
        chk("mon_status",      64'(status),      64'(e.st));
        chk("mon_err_latched", 64'(err_latched), 64'(e.el));
        chk("mon_cycle_count", 64'(cycle_count), 64'(e.cc));
        chk("mon_trace_count", 64'(trace_count), 64'(e.tc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (cif.core_clk_en && !cif.core_rst) n_run++;
    if (cif.core_clk_en &&  cif.core_rst) n_rph++;
    if (done) seen_done = 1'b1;
  endtask

  task automatic push(input logic [1:0] st, input logic [1:0] el, input int unsigned cc, input int unsigned tc);
    exp_t x;
    x.st = st; x.el = el; x.cc = cc; x.tc = tc;
    exp_q.push_back(x);
  endtask

  task automatic start_run(input logic [1:0] m, input logic with_abort);
    n_run = 0; n_rph = 0; seen_done = 1'b0;
    mode = m; start = 1'b1; abort = with_abort;
    tick();
    start = 1'b0; abort = 1'b0; mode = ~m;
  endtask

  task automatic run_to_done(input string name, input int budget);
    int i = 0;
    while (!seen_done && i < budget) begin
      tick();
      i++;
    end
    if (!seen_done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no done within %0d cycles, expected done", name, budget);
    end
  endtask

  task automatic run_until(input string name, input int target);
    int i = 0;
    while (n_run < target && i < 2000) begin
      tick();
      i++;
    end
    chk({name, "_reached"}, 64'(n_run), 64'(target));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; step = 1'b0; abort = 1'b0; mode = 2'b00; trace_rd_idx = '0;
    n_run = 0; n_rph = 0; seen_done = 1'b0;
    repeat (3) tick();
    chk("rst_core_rst",    64'(cif.core_rst),    1);
    chk("rst_core_clk_en", 64'(cif.core_clk_en), 0);
    chk("rst_busy",        64'(busy),            0);
    chk("rst_done",        64'(done),            0);
    chk("rst_status",      64'(status),          0);
    chk("rst_err_latched", 64'(err_latched),     0);
    chk("rst_cycle_count", 64'(cycle_count),     0);
    chk("rst_trace_count", 64'(trace_count),     0);
    rst = 1'b0;
    tick();

    // Budget run; abort coincident with start in IDLE must lose to start.
    push(ST_BUDGET, 2'b00, 750, 8);
    start_run(MODE_BUDGET, 1'b1);
    run_to_done("t1", 1000);
    chk("t1_reset_cycles", 64'(n_rph), 3);
    chk("t1_run_cycles",   64'(n_run), 750);
    chk("t1_clk_en_off",   64'(cif.core_clk_en), 0);

    // Halt on the 100th run cycle; trace holds cycles 93..100.
    halt_at = 100;
    push(ST_HALT, 2'b00, 100, 8);
    start_run(MODE_HALT, 1'b0);
    run_to_done("t2", 1000);
    chk("t2_run_cycles", 64'(n_run), 100);
    chk("t2_clk_en_off", 64'(cif.core_clk_en), 0);
    for (int i = 0; i < 8; i++) begin
      trace_rd_idx = 3'(i);
      #1;
      chk("t2_trace", 64'(trace_rd_data), 64'(BASE + 32'(92 + i)));
    end
    halt_at = 0;

    // Error and halt together: error has priority.
    halt_at = 40; err_at = 40; err_val = 2'b10;
    push(ST_ERR, 2'b10, 40, 8);
    start_run(MODE_HALT, 1'b0);
    run_to_done("t3", 1000);
    chk("t3_run_cycles", 64'(n_run), 40);
    halt_at = 0; err_at = 0; err_val = 2'b00;

    // Single-step: five pulses three cycles apart, then abort.
    start_run(MODE_STEP, 1'b0);
    repeat (4) tick();
    chk("t4_reset_cycles", 64'(n_rph), 3);
    chk("t4_idle_en",      64'(n_run), 0);
    for (int i = 0; i < 5; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      tick();
    end
    chk("t4_en_pulses",   64'(n_run), 5);
    chk("t4_cycle_count", 64'(cycle_count), 5);
    chk("t4_trace_count", 64'(trace_count), 5);
    chk("t4_busy",        64'(busy), 1);
    trace_rd_idx = 3'd0; #1;
    chk("t4_trace_oldest", 64'(trace_rd_data), 64'(BASE));
    trace_rd_idx = 3'd4; #1;
    chk("t4_trace_newest", 64'(trace_rd_data), 64'(BASE + 32'd4));
    trace_rd_idx = 3'd5; #1;
    chk("t4_trace_beyond", 64'(trace_rd_data), 0);
    push(ST_ABORT, 2'b00, 5, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    run_to_done("t4", 10);

    // Reset mid-run, then a clean re-run.
    start_run(MODE_BUDGET, 1'b0);
    run_until("t5", 200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_core_rst",    64'(cif.core_rst),    1);
    chk("t5_core_clk_en", 64'(cif.core_clk_en), 0);
    chk("t5_busy",        64'(busy),            0);
    chk("t5_cycle_count", 64'(cycle_count),     0);
    chk("t5_trace_count", 64'(trace_count),     0);
    chk("t5_status",      64'(status),          0);
    push(ST_BUDGET, 2'b00, 750, 8);
    start_run(MODE_BUDGET, 1'b0);
    run_to_done("t5", 1000);
    chk("t5_run_cycles",   64'(n_run), 750);
    chk("t5_reset_cycles", 64'(n_rph), 3);

    // start during RUN is ignored; start in DONE re-runs from a fresh reset.
    push(ST_BUDGET, 2'b00, 750, 8);
    start_run(MODE_BUDGET, 1'b0);
    run_until("t6", 300);
    chk("t6_count_before", 64'(cycle_count), 299);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_busy_kept",   64'(busy), 1);
    chk("t6_count_after", 64'(cycle_count), 300);
    run_to_done("t6", 1000);
    chk("t6_run_cycles", 64'(n_run), 750);
    halt_at = 10;
    push(ST_HALT, 2'b00, 10, 8);
    start_run(MODE_HALT, 1'b0);
    chk("t6_rerun_trace_count", 64'(trace_count), 0);
    chk("t6_rerun_cycle_count", 64'(cycle_count), 0);
    chk("t6_rerun_core_rst",    64'(cif.core_rst), 1);
    trace_rd_idx = 3'd0; #1;
    chk("t6_rerun_trace_data",  64'(trace_rd_data), 0);
    run_to_done("t6b", 1000);
    chk("t6b_reset_cycles", 64'(n_rph), 3);
    chk("t6b_run_cycles",   64'(n_run), 10);
    halt_at = 0;

    repeat (3) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
